red_pitaya_na_sweep_master: RTL

RED_PITAYA_NA_SWEEP_MASTER -- requirements
Module: red_pitaya_na_sweep_master

---
 rtl/red_pitaya_na_sweep_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_na_sweep_master.sv
// Network-analyser sweep sequencer: programs each frequency point over the register bus,
// polls the averaging engine until idle, then streams its four result words out.
module red_pitaya_na_sweep_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned POLL_GAP = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] f_start_i,
    input  logic [31:0] f_step_i,
    input  logic [15:0] n_points_i,
    output logic [15:0] addr_o,
    output logic        wen_o,
    output logic        ren_o,
    output logic [31:0] wdata_o,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic [15:0] res_idx_o,
    output logic [1:0]  res_word_o,
    input  logic        res_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CntMax = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StWrFreq, StWaitWr, StPollGap, StPoll,
        StWaitPoll, StRdWord, StWaitRd, StEmit, StDone
    } state_e;

    state_e          state_q;
    logic [31:0]     f_q;
    logic [31:0]     step_q;
    logic [15:0]     n_q;
    logic [15:0]     p_q;
    logic [1:0]      w_q;
    logic [CntW-1:0] cnt_q;
    logic            abort_q;

    logic in_wait;
    logic aborting;
    logic timed_out;

    assign busy_o    = (state_q != StIdle) && (state_q != StDone);
    assign done_o    = (state_q == StDone);
    assign in_wait   = (state_q == StWaitWr) || (state_q == StWaitPoll) || (state_q == StWaitRd);
    assign aborting  = abort_q || abort_i;
    // cnt_q counts cycles since the strobe, so the error lands exactly TIMEOUT cycles after it
    assign timed_out = in_wait && !ack_i && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            f_q         <= '0;
            step_q      <= '0;
            n_q         <= '0;
            p_q         <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            addr_o      <= '0;
            wen_o       <= 1'b0;
            ren_o       <= 1'b0;
            wdata_o     <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_idx_o   <= '0;
            res_word_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            wen_o <= 1'b0;
            ren_o <= 1'b0;
            if (busy_o && abort_i && !in_wait) begin
                // nothing outstanding: drop straight back to idle
                state_q     <= StIdle;
                res_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start_i) begin
                            f_q     <= f_start_i;
                            step_q  <= f_step_i;
                            n_q     <= n_points_i;
                            p_q     <= '0;
                            w_q     <= '0;
                            abort_q <= 1'b0;
                            err_o   <= 1'b0;
                            state_q <= (n_points_i == 16'd0) ? StDone : StWrFreq;
                        end
                    end
                    StWrFreq: begin
                        wen_o   <= 1'b1;
                        addr_o  <= 16'h0108;
                        wdata_o <= f_q;
                        cnt_q   <= '0;
                        state_q <= StWaitWr;
                    end
                    StWaitWr, StWaitPoll, StWaitRd: begin
                        if (abort_i) abort_q <= 1'b1;
                        if (ack_i) begin
                            if (aborting) begin
                                state_q <= StIdle;
                            end else if (state_q == StWaitWr) begin
                                cnt_q   <= CntW'(1);
                                state_q <= StPollGap;
                            end else if (state_q == StWaitPoll) begin
                                if (rdata_i[31]) begin
                                    cnt_q   <= CntW'(1);
                                    state_q <= StPollGap;
                                end else begin
                                    w_q     <= '0;
                                    state_q <= StRdWord;
                                end
                            end else begin
                                res_data_o  <= rdata_i;
                                res_idx_o   <= p_q;
                                res_word_o  <= w_q;
                                res_valid_o <= 1'b1;
                                state_q     <= StEmit;
                            end
                        end else if (timed_out) begin
                            err_o   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StPollGap: begin
                        if (cnt_q >= CntW'(POLL_GAP)) state_q <= StPoll;
                        else                           cnt_q   <= cnt_q + CntW'(1);
                    end
                    StPoll: begin
                        ren_o   <= 1'b1;
                        addr_o  <= 16'h0140;
                        cnt_q   <= '0;
                        state_q <= StWaitPoll;
                    end
                    StRdWord: begin
                        ren_o   <= 1'b1;
                        addr_o  <= 16'h0140 + {12'd0, w_q, 2'b00};
                        cnt_q   <= '0;
                        state_q <= StWaitRd;
                    end
                    StEmit: begin
                        if (res_ready_i) begin
                            res_valid_o <= 1'b0;
                            if (w_q == 2'd3) begin
                                w_q     <= '0;
                                p_q     <= p_q + 16'd1;
                                f_q     <= f_q + step_q;
                                state_q <= (p_q + 16'd1 == n_q) ? StDone : StWrFreq;
                            end else begin
                                w_q     <= w_q + 2'd1;
                                state_q <= StRdWord;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
